// File: rtl/alu_issue_stage.sv
// alu_issue_stage: issue stage in front of a registered, 1-cycle-latency ALU.
// Decodes R-type and I-type ALU instructions and drives registered funct3/funct7/operands
// (stage S1). It tags the ALU result one cycle later with its destination register
// (stage S2). A hold register keeps the S2 result stable while the consumer stalls.
// Build option: define ALU_ISSUE_FWD_EN to forward S2/writeback results into the operands.
// Without it, those producers raise a hazard instead.
module alu_issue_stage #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [DATA_WIDTH-1:0] in_rs1_data,
  input  logic [DATA_WIDTH-1:0] in_rs2_data,
  input  logic                  wb_we,
  input  logic [4:0]            wb_rd,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic [2:0]            alu_funct3,
  output logic                  alu_funct7,
  output logic [DATA_WIDTH-1:0] alu_opranda,
  output logic [DATA_WIDTH-1:0] alu_oprandb,
  input  logic [DATA_WIDTH-1:0] alu_res,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4:0]            out_rd,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  illegal
);

  localparam logic [6:0] OpR = 7'b0110011;
  localparam logic [6:0] OpI = 7'b0010011;

  logic [2:0]            funct3_q;
  logic                  funct7_q;
  logic [DATA_WIDTH-1:0] opA_q, opB_q;
  logic                  s1Valid_q, s2Valid_q;
  logic [4:0]            s1Rd_q, s2Rd_q;
  logic [DATA_WIDTH-1:0] hold_q;
  logic                  holdValid_q;
  logic                  illegal_q;

  logic                  isR, isI, isLegal, isShift;
  logic [2:0]            funct3_d;
  logic                  funct7_d;
  logic [4:0]            rd, rs1, rs2;
  logic [DATA_WIDTH-1:0] rs1Val, rs2Val, opB_d;
  logic                  hit1, hit2, hazard;
  logic                  adv2, accept, issue;

  function automatic logic rdMatch(input logic v, input logic [4:0] prodRd, input logic [4:0] rs);
    return v && (prodRd != 5'd0) && (prodRd == rs);
  endfunction

  // Field decode, funct7 selection and operand B choice for the offered instruction
  always_comb begin
    isR      = (in_instr[6:0] == OpR);
    isI      = (in_instr[6:0] == OpI);
    isLegal  = isR | isI;
    funct3_d = in_instr[14:12];
    rd       = in_instr[11:7];
    rs1      = in_instr[19:15];
    rs2      = in_instr[24:20];
    isShift  = isI && ((funct3_d == 3'b001) || (funct3_d == 3'b101));
    funct7_d = 1'b0;
    if (isR || (isI && funct3_d == 3'b101)) funct7_d = in_instr[30];
    opB_d = {{(DATA_WIDTH-12){in_instr[31]}}, in_instr[31:20]};
    if (isR)          opB_d = rs2Val;
    else if (isShift) opB_d = {{(DATA_WIDTH-5){1'b0}}, in_instr[24:20]};
  end

`ifdef ALU_ISSUE_FWD_EN
  // Source values with youngest-producer priority, and hazard only against the S1 producer
  always_comb begin
    rs1Val = in_rs1_data;
    if (rdMatch(s2Valid_q, s2Rd_q, rs1))  rs1Val = out_data;
    else if (rdMatch(wb_we, wb_rd, rs1))  rs1Val = wb_data;
    rs2Val = in_rs2_data;
    if (rdMatch(s2Valid_q, s2Rd_q, rs2))  rs2Val = out_data;
    else if (rdMatch(wb_we, wb_rd, rs2))  rs2Val = wb_data;
    hit1   = rdMatch(s1Valid_q, s1Rd_q, rs1);
    hit2   = rdMatch(s1Valid_q, s1Rd_q, rs2);
    hazard = isLegal && (hit1 || (isR && hit2));
  end
`else
  logic unusedWbData;
  assign unusedWbData = ^wb_data;

  // Regfile-only operands, so every in-flight producer (S1, S2, writeback) is a hazard
  always_comb begin
    rs1Val = in_rs1_data;
    rs2Val = in_rs2_data;
    hit1   = rdMatch(s1Valid_q, s1Rd_q, rs1) || rdMatch(s2Valid_q, s2Rd_q, rs1) ||
             rdMatch(wb_we, wb_rd, rs1);
    hit2   = rdMatch(s1Valid_q, s1Rd_q, rs2) || rdMatch(s2Valid_q, s2Rd_q, rs2) ||
             rdMatch(wb_we, wb_rd, rs2);
    hazard = isLegal && (hit1 || (isR && hit2));
  end
`endif

  assign adv2     = !s2Valid_q || out_ready;
  assign in_ready = (!s1Valid_q || adv2) && !hazard;
  assign accept   = in_valid && in_ready;
  assign issue    = accept && isLegal;

  // Pipeline state: operand regs load only on issue so a frozen S1 keeps alu_res valid,
  // and the hold reg grabs the S2 result before the ALU overwrites it during a stall
  always_ff @(posedge clk) begin
    if (rst) begin
      funct3_q    <= '0;
      funct7_q    <= 1'b0;
      opA_q       <= '0;
      opB_q       <= '0;
      s1Valid_q   <= 1'b0;
      s2Valid_q   <= 1'b0;
      s1Rd_q      <= '0;
      s2Rd_q      <= '0;
      hold_q      <= '0;
      holdValid_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      if (issue) begin
        funct3_q <= funct3_d;
        funct7_q <= funct7_d;
        opA_q    <= rs1Val;
        opB_q    <= opB_d;
        s1Rd_q   <= rd;
      end
      if (issue)     s1Valid_q <= 1'b1;
      else if (adv2) s1Valid_q <= 1'b0;
      if (adv2) begin
        s2Valid_q <= s1Valid_q;
        if (s1Valid_q) s2Rd_q <= s1Rd_q;
      end
      if (s2Valid_q && !out_ready && !holdValid_q) begin
        hold_q      <= alu_res;
        holdValid_q <= 1'b1;
      end else if (out_ready) begin
        holdValid_q <= 1'b0;
      end
      illegal_q <= accept && !isLegal;
    end
  end

  assign alu_funct3  = funct3_q;
  assign alu_funct7  = funct7_q;
  assign alu_opranda = opA_q;
  assign alu_oprandb = opB_q;
  assign out_valid   = s2Valid_q;
  assign out_rd      = s2Rd_q;
  assign out_data    = holdValid_q ? hold_q : alu_res;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: bench for alu_issue_stage with an in-order ISA reference model,
// a registered ALU, a regfile and a writeback path modelled around the DUT.
module tb_alu_issue_stage;

  logic        clk, rst;
  logic        in_valid, in_ready;
  logic [31:0] in_instr, in_rs1_data, in_rs2_data;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [2:0]  alu_funct3;
  logic        alu_funct7;
  logic [31:0] alu_opranda, alu_oprandb, alu_res;
  logic        out_valid, out_ready;
  logic [4:0]  out_rd;
  logic [31:0] out_data;
  logic        illegal;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] val;
  } resT;

  resT         expQ[$];
  logic [31:0] arch [32];
  logic [31:0] rf [32];
  logic        expIll;
  int          checks;
  int          errors;

  alu_issue_stage #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
    .alu_opranda(alu_opranda), .alu_oprandb(alu_oprandb), .alu_res(alu_res),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd), .out_data(out_data),
    .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] aluOp(input logic [2:0] f3, input logic alt,
                                        input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'b000:  return alt ? a - b : a + b;
      3'b001:  return a << b[4:0];
      3'b010:  return {31'b0, $signed(a) < $signed(b)};
      3'b011:  return {31'b0, a < b};
      3'b100:  return a ^ b;
      3'b101:  return alt ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'b110:  return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic isAlu(input logic [31:0] ins);
    return (ins[6:0] == 7'b0110011) || (ins[6:0] == 7'b0010011);
  endfunction

  // Architectural result of one instruction in program order, straight from the RV32I rules
  function automatic logic [31:0] isaExec(input logic [31:0] ins);
    logic [2:0]  f3;
    logic [31:0] a, b;
    logic        alt;
    f3 = ins[14:12];
    a  = arch[ins[19:15]];
    if (ins[6:0] == 7'b0110011) begin
      b   = arch[ins[24:20]];
      alt = ins[30];
    end else if (f3 == 3'b001 || f3 == 3'b101) begin
      b   = {27'b0, ins[24:20]};
      alt = (f3 == 3'b101) && ins[30];
    end else begin
      b   = {{20{ins[31]}}, ins[31:20]};
      alt = 1'b0;
    end
    return aluOp(f3, alt, a, b);
  endfunction

  function automatic logic [31:0] rType(input logic [6:0] f7, input logic [4:0] rs2v,
                                        input logic [4:0] rs1v, input logic [2:0] f3,
                                        input logic [4:0] rdv);
    return {f7, rs2v, rs1v, f3, rdv, 7'b0110011};
  endfunction

  function automatic logic [31:0] iType(input logic [11:0] imm, input logic [4:0] rs1v,
                                        input logic [2:0] f3, input logic [4:0] rdv);
    return {imm, rs1v, f3, rdv, 7'b0010011};
  endfunction

  function automatic logic [31:0] randInstr();
    logic [2:0]  f3;
    logic [11:0] imm;
    int          kind;
    kind = int'($urandom_range(0, 19));
    f3   = 3'($urandom_range(0, 7));
    imm  = 12'($urandom);
    if (kind < 2) begin
      case ($urandom_range(0, 3))
        0:       return {imm, 5'($urandom_range(0, 7)), 3'b010, 5'($urandom_range(0, 7)), 7'b0000011};
        1:       return {imm, 5'($urandom_range(0, 7)), 3'b010, 5'($urandom_range(0, 7)), 7'b0100011};
        2:       return {imm, 5'($urandom_range(0, 7)), f3, 5'($urandom_range(0, 7)), 7'b1100011};
        default: return {imm, 5'($urandom_range(0, 7)), f3, 5'($urandom_range(0, 7)), 7'b0110111};
      endcase
    end else if (kind < 11) begin
      return rType(($urandom_range(0, 1) != 0) ? 7'b0100000 : 7'b0000000,
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), f3,
                   5'($urandom_range(0, 7)));
    end else begin
      if (f3 == 3'b001) imm[11:5] = 7'b0;
      if (f3 == 3'b101) imm[11:5] = ($urandom_range(0, 1) != 0) ? 7'b0100000 : 7'b0;
      return iType(imm, 5'($urandom_range(0, 7)), f3, 5'($urandom_range(0, 7)));
    end
  endfunction

  // Registered ALU, regfile and writeback port that surround the stage in the real pipeline
  always @(posedge clk) begin
    alu_res <= aluOp(alu_funct3, alu_funct7, alu_opranda, alu_oprandb);
    if (rst) begin
      wb_we   <= 1'b0;
      wb_rd   <= 5'd0;
      wb_data <= 32'd0;
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else begin
      wb_we   <= out_valid && out_ready;
      wb_rd   <= out_rd;
      wb_data <= out_data;
      if (wb_we && wb_rd != 5'd0) rf[wb_rd] <= wb_data;
    end
  end

  assign in_rs1_data = rf[in_instr[19:15]];
  assign in_rs2_data = rf[in_instr[24:20]];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison against the reference model, then model update for this cycle's accept
  task automatic compareModel();
    logic [31:0] r;
    if (rst) begin
      expQ.delete();
      for (int i = 0; i < 32; i++) arch[i] = 32'd0;
      expIll = 1'b0;
    end else begin
      checkOutput("illegal", {31'b0, illegal}, {31'b0, expIll});
      if (out_valid) begin
        if (expQ.size() == 0) begin
          checkOutput("spurious_out_valid", 32'd1, 32'd0);
        end else begin
          checkOutput("model_out_rd", {27'b0, out_rd}, {27'b0, expQ[0].rd});
          checkOutput("model_out_data", out_data, expQ[0].val);
          if (out_ready) void'(expQ.pop_front());
        end
      end
      expIll = in_valid && in_ready && !isAlu(in_instr);
      if (in_valid && in_ready && isAlu(in_instr)) begin
        r = isaExec(in_instr);
        expQ.push_back('{rd: in_instr[11:7], val: r});
        if (in_instr[11:7] != 5'd0) arch[in_instr[11:7]] = r;
      end
    end
  endtask

  task automatic midCycle();
    @(negedge clk);
    compareModel();
  endtask

  task automatic endCycle();
    @(posedge clk);
    #1;
  endtask

  // Offers one instruction and returns just after the edge that accepted it
  task automatic applyStimulus(input logic [31:0] ins, output int stalls);
    logic acc;
    stalls   = 0;
    in_valid = 1'b1;
    in_instr = ins;
    for (int n = 0; n < 50; n++) begin
      midCycle();
      acc = in_ready;
      if (!acc) stalls++;
      endCycle();
      if (acc) return;
    end
    checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic waitResult(input logic [4:0] rdv, input logic [31:0] val, input string name);
    logic seen;
    seen     = 1'b0;
    in_valid = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      midCycle();
      if (out_valid && out_ready && out_rd == rdv) begin
        checkOutput(name, out_data, val);
        seen = 1'b1;
      end
      endCycle();
    end
    if (!seen) checkOutput({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic drain();
    logic idle;
    idle     = 1'b0;
    in_valid = 1'b0;
    for (int n = 0; n < 200 && !idle; n++) begin
      midCycle();
      idle = (expQ.size() == 0) && !out_valid && !wb_we;
      endCycle();
    end
    if (!idle) checkOutput("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int   st;
    logic lastAcc;
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_instr  = 32'd0;
    out_ready = 1'b1;
    repeat (2) begin midCycle(); endCycle(); end
    rst = 1'b0;
    midCycle();
    checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_alu_a", alu_opranda, 32'd0);
    checkOutput("rst_alu_b", alu_oprandb, 32'd0);
    checkOutput("rst_out_rd", {27'b0, out_rd}, 32'd0);
    endCycle();

    applyStimulus(iType(12'd5, 5'd0, 3'b000, 5'd1), st);
    applyStimulus(iType(12'd7, 5'd0, 3'b000, 5'd2), st);
    drain();
    applyStimulus(rType(7'b0, 5'd2, 5'd1, 3'b000, 5'd3), st);
    in_valid = 1'b0;
    midCycle();
    checkOutput("add_funct3", {29'b0, alu_funct3}, 32'd0);
    checkOutput("add_funct7", {31'b0, alu_funct7}, 32'd0);
    checkOutput("add_opa", alu_opranda, 32'd5);
    checkOutput("add_opb", alu_oprandb, 32'd7);
    checkOutput("add_early_valid", {31'b0, out_valid}, 32'd0);
    endCycle();
    midCycle();
    checkOutput("add_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("add_rd", {27'b0, out_rd}, 32'd3);
    checkOutput("add_data", out_data, 32'd12);
    endCycle();
    drain();

    applyStimulus(iType(12'd1, 5'd0, 3'b000, 5'd5), st);
    applyStimulus(iType(12'd31, 5'd5, 3'b001, 5'd5), st);
    drain();
    applyStimulus(rType(7'b0100000, 5'd1, 5'd3, 3'b000, 5'd9), st);
    in_instr = iType({7'b0100000, 5'd4}, 5'd5, 3'b101, 5'd4);
    midCycle();
    checkOutput("sub_funct7", {31'b0, alu_funct7}, 32'd1);
    checkOutput("srai_b2b_ready", {31'b0, in_ready}, 32'd1);
    endCycle();
    in_valid = 1'b0;
    midCycle();
    checkOutput("srai_funct7", {31'b0, alu_funct7}, 32'd1);
    checkOutput("sub_rd", {27'b0, out_rd}, 32'd9);
    checkOutput("sub_data", out_data, 32'd7);
    endCycle();
    midCycle();
    checkOutput("srai_rd", {27'b0, out_rd}, 32'd4);
    checkOutput("srai_data", out_data, 32'hF800_0000);
    endCycle();
    drain();

    applyStimulus(iType(12'hFFF, 5'd0, 3'b000, 5'd6), st);
    applyStimulus(iType(12'd0, 5'd6, 3'b010, 5'd7), st);
`ifdef ALU_ISSUE_FWD_EN
    checkOutput("slti_stalls", st, 32'd1);
`else
    checkOutput("slti_stalls", st, 32'd3);
`endif
    waitResult(5'd7, 32'd1, "slti_data");
    drain();

    out_ready = 1'b0;
    applyStimulus(iType(12'd100, 5'd0, 3'b000, 5'd10), st);
    applyStimulus(iType(12'd200, 5'd0, 3'b000, 5'd11), st);
    in_instr = iType(12'd3, 5'd0, 3'b000, 5'd12);
    for (int k = 0; k < 3; k++) begin
      midCycle();
      checkOutput("stall_rd", {27'b0, out_rd}, 32'd10);
      checkOutput("stall_data", out_data, 32'd100);
      checkOutput("stall_in_ready", {31'b0, in_ready}, 32'd0);
      endCycle();
    end
    out_ready = 1'b1;
    midCycle();
    checkOutput("held_first", out_data, 32'd100);
    endCycle();
    in_valid = 1'b0;
    midCycle();
    checkOutput("held_second_rd", {27'b0, out_rd}, 32'd11);
    checkOutput("held_second", out_data, 32'd200);
    endCycle();
    drain();

`ifndef ALU_ISSUE_FWD_EN
    applyStimulus(iType(12'd9, 5'd0, 3'b000, 5'd1), st);
    in_valid = 1'b0;
    repeat (2) begin midCycle(); endCycle(); end
    in_valid = 1'b1;
    in_instr = rType(7'b0, 5'd0, 5'd1, 3'b000, 5'd12);
    midCycle();
    checkOutput("wb_hazard_rd", {27'b0, wb_rd}, 32'd1);
    checkOutput("wb_hazard_ready", {31'b0, in_ready}, 32'd0);
    endCycle();
    midCycle();
    checkOutput("wb_hazard_release", {31'b0, in_ready}, 32'd1);
    endCycle();
    waitResult(5'd12, 32'd9, "wb_hazard_data");
    drain();
`endif

    applyStimulus({12'd0, 5'd1, 3'b010, 5'd8, 7'b0000011}, st);
    in_valid = 1'b0;
    midCycle();
    checkOutput("lw_illegal", {31'b0, illegal}, 32'd1);
    checkOutput("lw_no_valid", {31'b0, out_valid}, 32'd0);
    endCycle();
    midCycle();
    checkOutput("lw_illegal_pulse", {31'b0, illegal}, 32'd0);
    checkOutput("lw_still_no_valid", {31'b0, out_valid}, 32'd0);
    endCycle();

    out_ready = 1'b0;
    applyStimulus(iType(12'd1, 5'd0, 3'b000, 5'd13), st);
    applyStimulus(iType(12'd2, 5'd0, 3'b000, 5'd14), st);
    in_valid = 1'b0;
    rst = 1'b1;
    midCycle();
    endCycle();
    rst = 1'b0;
    midCycle();
    checkOutput("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("midrst_out_rd", {27'b0, out_rd}, 32'd0);
    checkOutput("midrst_alu_a", alu_opranda, 32'd0);
    endCycle();
    out_ready = 1'b1;

    lastAcc  = 1'b1;
    in_valid = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!in_valid || lastAcc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_instr = randInstr();
      end
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = (n % 1000 == 999);
      midCycle();
      lastAcc = in_valid && in_ready;
      endCycle();
    end
    rst       = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
